// File: rtl/mdio_pkg.sv
// Shared constants and types for the MDIO request arbiter.
// Command encodings match mdio_ctrl_module's op_cmd field.
package mdio_pkg;

  localparam logic [1:0] P_MDIO_W = 2'b01;
  localparam logic [1:0] P_MDIO_R = 2'b10;

  localparam logic [4:0] P_DEF_PHY_ADDR = 5'd0;
  localparam logic [4:0] P_DEF_REG_ADDR = 5'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } mdio_state_e;

  function automatic logic cmd_is_legal(input logic [1:0] cmd);
    return (cmd == P_MDIO_W) || (cmd == P_MDIO_R);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping.
// The pointer register itself lives in the caller.
module rr_arbiter #(
  parameter int P_REQ_NUM = 3,
  parameter int P_IDX_W   = 2
) (
  input  logic [P_REQ_NUM-1:0] req,
  input  logic [P_IDX_W-1:0]   ptr,
  output logic [P_REQ_NUM-1:0] grant,
  output logic [P_IDX_W-1:0]   idx
);

  int                 cand;
  logic [P_IDX_W-1:0] cand_idx;
  logic               found;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      cand     = (int'(ptr) + i) % P_REQ_NUM;
      cand_idx = P_IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one MDIO controller among P_REQ_NUM requesters: round-robin grant,
// one transaction in flight, per-requester completion pulse with data and error.
module mdio_arbiter
  import mdio_pkg::*;
#(
  parameter int P_REQ_NUM = 3,
  parameter int P_GUARD   = 2,
  parameter int P_TIMEOUT = 255
) (
  input  logic                    w_mdio_clk,
  input  logic                    i_sysrst,
  input  logic [P_REQ_NUM-1:0]    i_req_valid,
  output logic [P_REQ_NUM-1:0]    o_req_ready,
  input  logic [5*P_REQ_NUM-1:0]  i_req_phy_addr,
  input  logic [5*P_REQ_NUM-1:0]  i_req_reg_addr,
  input  logic [16*P_REQ_NUM-1:0] i_req_data,
  input  logic [2*P_REQ_NUM-1:0]  i_req_cmd,
  output logic [P_REQ_NUM-1:0]    o_rsp_valid,
  output logic [15:0]             o_rsp_data,
  output logic                    o_rsp_err,
  output logic [4:0]              o_phy_addr,
  output logic [4:0]              o_reg_addr,
  output logic [15:0]             o_reg_data,
  output logic [1:0]              o_op_cmd,
  output logic                    o_op_valid,
  input  logic                    i_op_ready,
  input  logic [15:0]             i_read_data,
  input  logic                    i_read_valid,
  output logic                    o_busy
);

  localparam int         IW        = (P_REQ_NUM > 2) ? $clog2(P_REQ_NUM) : 1;
  localparam logic [7:0] GUARD_C   = 8'(P_GUARD);
  localparam logic [7:0] TIMEOUT_C = 8'(P_TIMEOUT);

  mdio_state_e state, state_nxt;

  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        arb_idx;
  logic [P_REQ_NUM-1:0] arb_grant;
  logic [P_REQ_NUM-1:0] win_onehot;
  logic [7:0]           wait_cnt;
  logic [15:0]          rd_data;
  logic                 rd_got;

  logic [4:0]  sel_phy;
  logic [4:0]  sel_reg;
  logic [15:0] sel_data;
  logic [1:0]  sel_cmd;

  logic is_read;
  logic illegal;
  logic cap_now;
  logic timeout_now;
  logic wait_exit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
    return (p == IW'(P_REQ_NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(
    .P_REQ_NUM (P_REQ_NUM),
    .P_IDX_W   (IW)
  ) u_rr (
    .req   (i_req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    sel_phy  = '0;
    sel_reg  = '0;
    sel_data = '0;
    sel_cmd  = '0;
    for (int k = 0; k < P_REQ_NUM; k++) begin
      if (arb_grant[k]) begin
        sel_phy  = i_req_phy_addr[5*k +: 5];
        sel_reg  = i_req_reg_addr[5*k +: 5];
        sel_data = i_req_data[16*k +: 16];
        sel_cmd  = i_req_cmd[2*k +: 2];
      end
    end
  end

  // o_op_cmd doubles as the latched command for the whole transaction
  assign is_read     = (o_op_cmd == P_MDIO_R);
  assign illegal     = !cmd_is_legal(o_op_cmd);
  assign win_onehot  = P_REQ_NUM'(1) << win_idx;
  assign cap_now     = (state == ST_WAIT) && i_read_valid && is_read;
  assign timeout_now = (wait_cnt == TIMEOUT_C);
  assign wait_exit   = (state == ST_WAIT) &&
                       (((wait_cnt > GUARD_C) && i_op_ready) || timeout_now);

  always_ff @(posedge w_mdio_clk or posedge i_sysrst) begin
    if (i_sysrst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if ((|i_req_valid) && i_op_ready) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = illegal ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (wait_exit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the transition into the state they belong to
  always_ff @(posedge w_mdio_clk or posedge i_sysrst) begin
    if (i_sysrst) begin
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_phy_addr  <= '0;
      o_reg_addr  <= '0;
      o_reg_data  <= '0;
      o_op_cmd    <= '0;
      o_op_valid  <= 1'b0;
      o_busy      <= 1'b0;
      win_idx     <= '0;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      rd_got      <= 1'b0;
    end else begin
      o_req_ready <= '0;
      o_op_valid  <= 1'b0;
      o_rsp_valid <= '0;
      o_busy      <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_GRANT) begin
            win_idx     <= arb_idx;
            o_req_ready <= arb_grant;
            o_phy_addr  <= sel_phy;
            o_reg_addr  <= sel_reg;
            o_reg_data  <= sel_data;
            o_op_cmd    <= sel_cmd;
          end
        end
        ST_GRANT: begin
          wait_cnt <= '0;
          rd_got   <= 1'b0;
          if (illegal) begin
            o_rsp_valid <= win_onehot;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b1;
          end else begin
            o_op_valid <= 1'b1;
          end
        end
        // counting from ISSUE makes the timeout response land P_TIMEOUT+1 cycles after op_valid
        ST_ISSUE: wait_cnt <= sat_inc(wait_cnt);
        ST_WAIT: begin
          wait_cnt <= sat_inc(wait_cnt);
          if (cap_now) rd_got <= 1'b1;
          if (wait_exit) begin
            o_rsp_valid <= win_onehot;
            o_rsp_data  <= cap_now ? i_read_data : rd_data;
            o_rsp_err   <= timeout_now | (is_read & ~(rd_got | cap_now));
          end
        end
        ST_DONE:  rr_ptr <= ptr_next(win_idx);
        default:  ;
      endcase
    end
  end

  always_ff @(posedge w_mdio_clk) begin
    if (state == ST_GRANT) rd_data <= '0;
    else if (cap_now)      rd_data <= i_read_data;
  end

endmodule
